// File: rtl/gam_seq_sqrt_pkg.sv
// gam_seq_sqrt shared types and widths.
// Holds the FSM encoding and the norm-path radicand width.
package gam_seq_sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } sqrt_state_t;

   localparam int SQRT_IN_W = 32;

   localparam int VECTOR_LEN = 4;
   localparam int ELEM_W     = 15;

   // sum of VECTOR_LEN squares, padded up to an even width
   function automatic int norm_in_w(input int vlen, input int ew);
      int w;
      w = 2 * ew + $clog2(vlen);
      return w + (w % 2);
   endfunction

   localparam int NORM_IN_W = norm_in_w(VECTOR_LEN, ELEM_W);

endpackage

// File: rtl/gam_seq_sqrt_step.sv
// gam_seq_sqrt_step: one combinational digit-by-digit root iteration.
// Consumes two radicand bits, yields the next remainder and root.
module gam_seq_sqrt_step #(
   parameter int OUT_W = 16
) (
   input  logic [OUT_W+1:0] rem_acc,
   input  logic [OUT_W-1:0] root_acc,
   input  logic [1:0]       rad_bits,
   output logic [OUT_W+1:0] rem_nxt,
   output logic [OUT_W-1:0] root_nxt
);

   logic [OUT_W+3:0] t;
   logic [OUT_W+3:0] trial;
   logic [OUT_W+3:0] d;
   logic [OUT_W+3:0] sel;
   logic [1:0]       unused_hi;
   logic             ge;

   assign t     = {rem_acc, rad_bits};
   assign trial = {2'b00, root_acc, 2'b01};
   assign ge    = (t >= trial);
   assign d     = t - trial;
   assign sel   = ge ? d : t;

   // remainder never exceeds 2*root, so the top bits are always zero
   assign {unused_hi, rem_nxt} = sel;
   assign root_nxt = {root_acc[OUT_W-2:0], ge};

endmodule

// File: rtl/gam_seq_sqrt.sv
// gam_seq_sqrt: handshaked fixed-latency integer square root.
// Define GAM_SQRT_ROUND_EN to round out_root to nearest.
module gam_seq_sqrt
   import gam_seq_sqrt_pkg::*;
#(
   parameter int IN_W = SQRT_IN_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_W-1:0]      in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IN_W/2-1:0]    out_root,
   output logic [IN_W/2:0]      out_rem,
   output logic                 busy
);

   localparam int OUT_W = IN_W / 2;
   localparam int IT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [IT_W-1:0] LAST = IT_W'(OUT_W - 1);

   sqrt_state_t state, state_nxt;

   logic [IN_W-1:0]  rad;
   logic [OUT_W+1:0] rem_acc;
   logic [OUT_W-1:0] root_acc;
   logic [IT_W-1:0]  iter;
   logic [OUT_W+1:0] rem_nxt;
   logic [OUT_W-1:0] root_nxt;
   logic             load;
   logic             step;

   gam_seq_sqrt_step #(
      .OUT_W(OUT_W)
   ) u_step (
      .rem_acc (rem_acc),
      .root_acc(root_acc),
      .rad_bits(rad[IN_W-1:IN_W-2]),
      .rem_nxt (rem_nxt),
      .root_nxt(root_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (iter == LAST) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rad      <= '0;
         rem_acc  <= '0;
         root_acc <= '0;
         iter     <= '0;
      end else if (load) begin
         rad      <= in_data;
         rem_acc  <= '0;
         root_acc <= '0;
         iter     <= '0;
      end else if (step) begin
         rad      <= {rad[IN_W-3:0], 2'b00};
         rem_acc  <= rem_nxt;
         root_acc <= root_nxt;
         iter     <= iter + 1'b1;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_rem   = rem_acc[OUT_W:0];

`ifdef GAM_SQRT_ROUND_EN
   logic rnd_up;

   // round up when the remainder passes the half point; saturate at max
   assign rnd_up   = (state == DONE)
                   && (rem_acc[OUT_W:0] > {1'b0, root_acc})
                   && !(&root_acc);
   assign out_root = rnd_up ? root_acc + 1'b1 : root_acc;
`else
   assign out_root = root_acc;
`endif

endmodule

// File: tb/tb_gam_seq_sqrt.sv
// tb_gam_seq_sqrt: random and directed checks of gam_seq_sqrt
// against a binary-search square-root model.
module tb_gam_seq_sqrt;

   localparam int IN_W  = 32;
   localparam int OUT_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [IN_W-1:0]   in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [OUT_W-1:0]  out_root;
   logic [OUT_W:0]    out_rem;
   logic              busy;

   gam_seq_sqrt #(
      .IN_W(IN_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_root (out_root),
      .out_rem  (out_rem),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint root;
      longint rem;
      int     cyc;
      bit     seen;
   } exp_t;

   exp_t exp_q[$];
   int   npass = 0;
   int   ntot  = 0;
   int   cyc   = 0;
   bit   took  = 0;

   function automatic void chk(input string n, input longint a,
                               input longint e);
      ntot++;
      if (a == e) npass++;
      else $display("FAIL %s: got %0d expected %0d", n, a, e);
   endfunction

   function automatic void model(input longint x, output longint r,
                                 output longint m);
      longint lo, hi, mid;
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= x) lo = mid;
         else hi = mid - 1;
      end
      r = lo;
      m = x - lo * lo;
`ifdef GAM_SQRT_ROUND_EN
      if (m > r && r != 65535) r = r + 1;
`endif
   endfunction

   function automatic logic [31:0] gen();
      longint r, v;
      case ($urandom % 5)
         0: v = $urandom;
         1: v = $urandom % 1024;
         2: begin r = $urandom % 65536; v = r * r; end
         3: begin r = $urandom % 65536; v = r * r + 2 * r; end
         default: v = 64'hFFFFFFFF - ($urandom % 4);
      endcase
      return v[31:0];
   endfunction

   always @(posedge clk) cyc++;

   // compare process: every DONE cycle is checked against the queue head
   always @(negedge clk) begin
      exp_t e;
      took = 0;
      if (rst_n) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               e = exp_q[0];
               chk("root", longint'(out_root), e.root);
               chk("rem", longint'(out_rem), e.rem);
               chk("in_ready_done", longint'(in_ready), 0);
               if (!e.seen) begin
                  chk("latency", cyc, e.cyc + 1 + OUT_W);
                  exp_q[0].seen = 1;
               end
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            longint r, m;
            model(longint'(in_data), r, m);
            e.root = r;
            e.rem  = m;
            e.cyc  = cyc;
            e.seen = 0;
            exp_q.push_back(e);
            took = 1;
         end
      end
   end

   task automatic wait_accept();
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_valid();
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      if (!ok) chk("valid_timeout", 0, 1);
   endtask

   task automatic run_one(input logic [31:0] x, input longint er,
                          input longint em);
      @(posedge clk); #1;
      in_valid  = 1;
      in_data   = x;
      out_ready = 0;
      wait_accept();
      @(posedge clk); #1;
      in_valid = 0;
      wait_valid();
      chk("lit_root", longint'(out_root), er);
      chk("lit_rem", longint'(out_rem), em);
      @(posedge clk); #1;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
   endtask

   initial begin
      longint r, m;
      int sent, guard;
      logic [OUT_W-1:0] r0;
      logic [OUT_W:0]   m0;

      model(200, r, m);
      chk("model_200_root", r, 14);
      chk("model_200_rem", m, 4);
      model(64'hFFFFFFFF, r, m);
      chk("model_max_root", r, 65535);
      chk("model_max_rem", m, 131070);

      repeat (2) @(negedge clk);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_root", longint'(out_root), 0);
      chk("rst_rem", longint'(out_rem), 0);
      #2 rst_n = 1;

      run_one(32'd0, 0, 0);
      run_one(32'd144, 12, 0);
      run_one(32'd200, 14, 4);
      run_one(32'hFFFFFFFF, 65535, 131070);

      // backpressure with a competing offer held during DONE
      @(posedge clk); #1;
      in_valid = 1;
      in_data  = 32'd1000;
      wait_accept();
      @(posedge clk); #1;
      in_data = 32'd5000;
      wait_valid();
      r0 = out_root;
      m0 = out_rem;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", longint'(out_valid), 1);
         chk("bp_root", longint'(out_root), longint'(r0));
         chk("bp_rem", longint'(out_rem), longint'(m0));
         chk("bp_in_ready", longint'(in_ready), 0);
      end
      @(posedge clk); #1;
      out_ready = 1;
      @(negedge clk);
      chk("retire_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1;
      out_ready = 0;
      @(negedge clk);
      chk("post_retire_in_ready", longint'(in_ready), 1);
      chk("post_retire_valid", longint'(out_valid), 0);
      @(posedge clk); #1;
      in_valid = 0;
      wait_valid();
      @(posedge clk); #1;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;

      // reset in the middle of the iterations
      in_valid = 1;
      in_data  = gen();
      wait_accept();
      @(posedge clk); #1;
      in_valid = 0;
      repeat (8) @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_in_ready", longint'(in_ready), 1);
      chk("mid_rst_valid", longint'(out_valid), 0);
      chk("mid_rst_busy", longint'(busy), 0);
      chk("mid_rst_root", longint'(out_root), 0);
      chk("mid_rst_rem", longint'(out_rem), 0);
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1;
      run_one(32'd81, 9, 0);

      // random stream with random backpressure
      sent  = 0;
      guard = 0;
      while ((sent < 60 || exp_q.size() != 0 || in_valid)
             && guard < 20000) begin
         @(posedge clk); #1;
         guard++;
         if (in_valid && took) begin
            in_valid = 0;
            sent++;
         end
         if (!in_valid && sent < 60 && ($urandom % 3) == 0) begin
            in_valid = 1;
            in_data  = gen();
         end
         out_ready = (($urandom % 4) != 0);
      end
      if (guard >= 20000) chk("random_timeout", 0, 1);
      in_valid  = 0;
      out_ready = 0;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/gam_seq_sqrt.md
# gam_seq_sqrt

Sequential, handshaked unsigned integer square-root unit. It closes the loop on the squaring path: it takes a sum of squares, as produced by the square/accumulate datapath, and returns the integer magnitude floor(sqrt(x)) plus the remainder. It uses a fixed-latency digit-by-digit (two radicand bits per cycle) algorithm. It is a streaming block placed downstream of the squared-results adder in the GAM vector datapath.

## Interface
Parameters:
- IN_W, default 32: radicand width in bits; must be even and ≥ 4.
- OUT_W, derived: localparam equal to IN_W/2, the root width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- in_valid, input, 1: radicand offered.
- in_ready, output, 1: unit can accept.
- in_data, input, IN_W: unsigned radicand.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream accepts result.
- out_root, output, OUT_W: floor(sqrt(in_data)).
- out_rem, output, OUT_W+1: in_data − out_root².
- busy, output, 1: high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load the radicand shift register with in_data, clear rem_acc and root_acc, set iter = 0, go to CALC.
- CALC, one iteration per cycle:
  - Form the two-bit shift: t = (rem_acc << 2) | next two radicand MSBs.
  - Form the trial value: d = t − ((root_acc << 2) | 1), computed OUT_W+3 bits wide.
  - If d ≥ 0: rem_acc = d and root_acc = (root_acc << 1) | 1.
  - Else: rem_acc = t and root_acc = root_acc << 1.
  - Shift the radicand left by 2; increment iter.
  - After iteration OUT_W−1, go to DONE.
- DONE:
  - out_valid = 1; out_root and out_rem driven from the accumulators and held stable until accepted.
  - On out_ready: go to IDLE.
- There is only one transaction in flight. in_ready is 0 in CALC and DONE, including the cycle in which out_ready retires a result; that result and a new input are never accepted on the same edge.
- There is no early termination. Latency is fixed for every input value, including 0.
- The input is unsigned. A value with its MSB set is a legal large radicand and is not an error.
- Widths: rem_acc is OUT_W+2 bits internally; only the low OUT_W+1 bits are exposed, and the final remainder is always ≤ 2·root.

## Timing
- Reset values, asynchronous on rst_n low:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - out_root = 0, out_rem = 0, all accumulators and iter = 0.
- Reset asserted mid-CALC or mid-DONE aborts the transaction with no output; after release, the unit is in IDLE and ready on the first edge.
- Latency, with the acceptance edge as E0:
  - CALC iterations execute on edges E1..E(OUT_W).
  - out_valid rises after edge E(OUT_W).
  - This gives OUT_W cycles from acceptance to first out_valid; 16 for the default.
- Throughput: at best one result per OUT_W+2 cycles (accept, OUT_W iterations, one retiring DONE cycle).
- in_ready and out_valid are registered state decodes; there is no combinational path from in_valid or out_ready to any output.

## Configuration
- GAM_SQRT_ROUND_EN:
  - Defined: in DONE, out_root is rounded to nearest. If out_rem > out_root, out_root is incremented (saturating at 2^OUT_W−1) and out_rem is then the unrounded remainder, unchanged.
  - Not defined: out_root is the truncated floor result.
  - Latency and handshakes are identical in both builds.

## Structure
- GAM_package holds:
  - the typedef enum sqrt_state_t {IDLE, CALC, DONE};
  - the constant SQRT_IN_W = 32, used as the IN_W default at integration;
  - the dependency of the radicand width on VECTOR_LEN for the norm path.
- Sub-module gam_sqrt_step: combinational single iteration. Inputs rem_acc, root_acc, two radicand bits; outputs next rem_acc and next root_acc. It is instantiated once in the iteration loop.

## Test plan
- in_data = 0 → after 16 cycles, out_root = 0 and out_rem = 0.
- in_data = 144 → out_root = 12, out_rem = 0.
- in_data = 200 → out_root = 14, out_rem = 4. With GAM_SQRT_ROUND_EN: out_root = 14, since 4 ≤ 14.
- in_data = 0xFFFFFFFF → out_root = 65535, out_rem = 131070. With GAM_SQRT_ROUND_EN: out_root = 65535, saturated.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid, out_root and out_rem stay stable and in_ready stays 0. A new in_valid offered during DONE is not accepted until the cycle after retirement.
- Reset mid-operation: pull rst_n low at iteration 8 → outputs go to reset values immediately. After release, in_data = 81 gives out_root = 9, out_rem = 0, with normal latency.
